// File: rtl/mic_pdm_rx_pkg.sv
// mic_pkg: definitions shared by the PDM microphone front end and its
// neighbours in the mic path.
//   MIC_DECIM_DEFAULT : default number of PDM bits per PCM sample
//   mic_sample_w()    : signed PCM width that holds -decim..+decim
//   mic_sample_t      : PCM sample type at the default decimation
package mic_pkg;

  localparam int MIC_DECIM_DEFAULT = 64;

  // A window of decim bits yields 2*ones - decim, which spans -decim..+decim.
  // +decim needs log2(decim)+1 magnitude bits plus a sign bit.
  function automatic int mic_sample_w(input int decim);
    return $clog2(decim) + 2;
  endfunction

  typedef logic signed [mic_sample_w(MIC_DECIM_DEFAULT)-1:0] mic_sample_t;

endpackage

// File: rtl/mic_pdm_rx_if.sv
// mic_pdm_rx_if: valid/ready PCM sample channel from the PDM front end to
// the feature pipeline.
//   sample       : signed PCM sample, two's complement (producer -> consumer)
//   sample_valid : sample holds an unconsumed value (producer -> consumer)
//   sample_ready : consumer accepts sample this cycle (consumer -> producer)
// Modports: master = sample producer, slave = sample consumer.
interface mic_pdm_rx_if
  import mic_pkg::*;
#(
  parameter int SAMPLE_W = mic_sample_w(MIC_DECIM_DEFAULT)
) ();

  logic signed [SAMPLE_W-1:0] sample;
  logic                       sample_valid;
  logic                       sample_ready;

  modport master (
    output sample,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/mic_pdm_rx_sync2.sv
// mic_sync2: two-flop synchronizer for asynchronous microphone pins.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   d     : asynchronous input
//   q     : synchronized output, two clk cycles behind d
module mic_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mic_pdm_rx.sv
// mic_pdm_rx: PDM microphone front end. Drives the microphone clock from the
// divider's half-period tick, captures the left-channel PDM bit on the high
// phase, and decimates DECIM bits with a ones-count (boxcar) filter into a
// signed PCM sample 2*ones - DECIM held in a single-entry output register.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   tick     : one-cycle strobe, one half-period of mic_clk
//   en       : capture enable; low forces mic_clk to 0 and discards the window
//   mic_data : asynchronous PDM data pin
//   mic_clk  : microphone clock pin
//   overrun  : sticky "sample dropped" flag, cleared only by reset
//              (present only when MIC_PDM_OVERRUN_EN is defined)
//   pcm      : mic_pdm_rx_if.master, sample / sample_valid / sample_ready
// Build option: define MIC_PDM_OVERRUN_EN to add the overrun port/register.
// Without it a full output register still drops new samples, silently.
module mic_pdm_rx
  import mic_pkg::*;
#(
  parameter int DECIM    = MIC_DECIM_DEFAULT,
  parameter int SAMPLE_W = mic_sample_w(DECIM)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         en,
  input  logic         mic_data,
  output logic         mic_clk,
`ifdef MIC_PDM_OVERRUN_EN
  output logic         overrun,
`endif
  mic_pdm_rx_if.master pcm
);

  localparam int CNT_W  = $clog2(DECIM);
  localparam int ONES_W = CNT_W + 1;

  logic                pdm_s;
  logic [CNT_W-1:0]    bit_cnt;
  logic [ONES_W-1:0]   ones;
  logic [ONES_W-1:0]   total;
  logic [SAMPLE_W-1:0] result;
  logic [SAMPLE_W-1:0] sample_q;
  logic                valid_q;
  logic                capture;
  logic                window_close;
  logic                xfer;

  mic_sync2 u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (mic_data),
    .q    (pdm_s)
  );

  // The tick that ends the high phase is the capture point: data is valid
  // while mic_clk is high and the falling edge follows on the same tick.
  assign capture      = en & tick & mic_clk;
  assign window_close = capture & (bit_cnt == CNT_W'(DECIM - 1));
  assign total        = ones + ONES_W'(pdm_s);
  // Zero-extend 2*total before subtracting so the full 0..2*DECIM range
  // maps onto -DECIM..+DECIM in two's complement.
  assign result       = SAMPLE_W'({total, 1'b0}) - SAMPLE_W'(DECIM);
  assign xfer         = valid_q & pcm.sample_ready;

  // Microphone clock and window accumulator. Dropping en discards any
  // partial window so the next enable starts a clean one with mic_clk low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mic_clk <= 1'b0;
      bit_cnt <= '0;
      ones    <= '0;
    end else if (!en) begin
      mic_clk <= 1'b0;
      bit_cnt <= '0;
      ones    <= '0;
    end else if (tick) begin
      mic_clk <= ~mic_clk;
      if (mic_clk) begin
        if (window_close) begin
          bit_cnt <= '0;
          ones    <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          ones    <= total;
        end
      end
    end
  end

  // Single-entry output register. A result may load when the register is
  // empty or is being emptied this very cycle; otherwise it is dropped and
  // the pending sample is left untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else if (window_close && (!valid_q || xfer)) begin
      sample_q <= result;
      valid_q  <= 1'b1;
    end else if (xfer) begin
      valid_q  <= 1'b0;
    end
  end

`ifdef MIC_PDM_OVERRUN_EN
  // Sticky record that at least one result was dropped since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (window_close && valid_q && !xfer) begin
      overrun <= 1'b1;
    end
  end
`endif

  assign pcm.sample       = sample_q;
  assign pcm.sample_valid = valid_q;

endmodule

// File: tb/tb_mic_pdm_rx.sv
// tb_mic_pdm_rx: scoreboard bench for mic_pdm_rx. Two instances (DECIM=8 and
// DECIM=64) share one PDM stream, tick, en and sample_ready. The stimulus
// side counts ones per window and announces each window result; a monitor
// owns the expected-sample queues, decides load/drop from the queue occupancy
// and compares every cycle on the falling clock edge.
// Honours MIC_PDM_OVERRUN_EN by also checking the overrun flags.
module tb_mic_pdm_rx;

  logic clk = 1'b0;
  logic rst_n;
  logic tick;
  logic en;
  logic mic_data;
  logic ready;
  logic mic_clk8;
  logic mic_clk64;
`ifdef MIC_PDM_OVERRUN_EN
  logic ovr8;
  logic ovr64;
`endif

  mic_pdm_rx_if #(.SAMPLE_W(5)) if8 ();
  mic_pdm_rx_if #(.SAMPLE_W(8)) if64 ();

  assign if8.sample_ready  = ready;
  assign if64.sample_ready = ready;

  mic_pdm_rx #(.DECIM(8)) dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .en      (en),
    .mic_data(mic_data),
    .mic_clk (mic_clk8),
`ifdef MIC_PDM_OVERRUN_EN
    .overrun (ovr8),
`endif
    .pcm     (if8)
  );

  mic_pdm_rx #(.DECIM(64)) dut64 (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .en      (en),
    .mic_data(mic_data),
    .mic_clk (mic_clk64),
`ifdef MIC_PDM_OVERRUN_EN
    .overrun (ovr64),
`endif
    .pcm     (if64)
  );

  always #5 clk = ~clk;

  // Stimulus-side reference state: ones count per window, announced results
  int ones8, cnt8, ones64, cnt64;
  int cval8, cval64;
  int close8_req  = 0;
  int close64_req = 0;
  bit stim_phase;
  int ready_mode;
  bit ready_at_close;

  // Monitor-side state: expected output registers and statistics
  int q8[$];
  int q64[$];
  int seen8, seen64;
  int drops8, drops64;
  bit mclk_exp;
  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: compare the state left by the last rising edge, then apply
  // what the coming edge will do (transfer, load or drop, mic_clk toggle).
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      #1;
      checkOutput("rst_valid8",   int'(if8.sample_valid),   0);
      checkOutput("rst_sample8",  int'($signed(if8.sample)), 0);
      checkOutput("rst_mic_clk8", int'(mic_clk8),           0);
      checkOutput("rst_valid64",  int'(if64.sample_valid),  0);
      checkOutput("rst_sample64", int'($signed(if64.sample)), 0);
      checkOutput("rst_mic_clk64", int'(mic_clk64),         0);
`ifdef MIC_PDM_OVERRUN_EN
      checkOutput("rst_overrun8",  int'(ovr8),  0);
      checkOutput("rst_overrun64", int'(ovr64), 0);
`endif
      q8.delete();
      q64.delete();
      drops8   = 0;
      drops64  = 0;
      mclk_exp = 1'b0;
      seen8    = close8_req;
      seen64   = close64_req;
    end else begin
      checkOutput("mic_clk8",  int'(mic_clk8),  int'(mclk_exp));
      checkOutput("mic_clk64", int'(mic_clk64), int'(mclk_exp));
      checkOutput("valid8",  int'(if8.sample_valid),  int'(q8.size() != 0));
      checkOutput("valid64", int'(if64.sample_valid), int'(q64.size() != 0));
      if (q8.size() != 0)  checkOutput("sample8",  int'($signed(if8.sample)),  q8[0]);
      if (q64.size() != 0) checkOutput("sample64", int'($signed(if64.sample)), q64[0]);
`ifdef MIC_PDM_OVERRUN_EN
      checkOutput("overrun8",  int'(ovr8),  int'(drops8 != 0));
      checkOutput("overrun64", int'(ovr64), int'(drops64 != 0));
`endif
      if (ready && q8.size() != 0)  void'(q8.pop_front());
      if (ready && q64.size() != 0) void'(q64.pop_front());
      if (seen8 != close8_req) begin
        seen8 = close8_req;
        if (q8.size() == 0) q8.push_back(cval8);
        else drops8++;
      end
      if (seen64 != close64_req) begin
        seen64 = close64_req;
        if (q64.size() == 0) q64.push_back(cval64);
        else drops64++;
      end
      if (!en) mclk_exp = 1'b0;
      else if (tick) mclk_exp = !mclk_exp;
    end
  end

  // Advance one clock; inputs change 1 time unit after the rising edge
  task automatic cycle();
    @(posedge clk);
    #1;
    tick = 1'b0;
    case (ready_mode)
      0:       ready = 1'b0;
      1:       ready = 1'b1;
      2:       ready = 1'($urandom_range(0, 1));
      default: ready = 1'b0;
    endcase
  endtask

  // One tick followed by 15 quiet cycles; a tick in the high phase captures
  task automatic sendTick();
    tick = 1'b1;
    if (en) begin
      if (stim_phase) begin
        ones8  += int'(mic_data);
        ones64 += int'(mic_data);
        cnt8++;
        cnt64++;
        if (cnt8 == 8) begin
          cval8 = 2 * ones8 - 8;
          close8_req++;
          if (ready_at_close) ready = 1'b1;
          ones8 = 0;
          cnt8  = 0;
        end
        if (cnt64 == 64) begin
          cval64 = 2 * ones64 - 64;
          close64_req++;
          ones64 = 0;
          cnt64  = 0;
        end
      end
      stim_phase = !stim_phase;
    end
    repeat (16) cycle();
  endtask

  // One PDM bit: present the data, raise mic_clk, then capture
  task automatic applyStimulus(input bit b);
    mic_data = b;
    sendTick();
    sendTick();
  endtask

  task automatic setEnable(input bit v);
    en = v;
    if (!v) begin
      ones8 = 0; cnt8 = 0; ones64 = 0; cnt64 = 0;
      stim_phase = 1'b0;
    end
  endtask

  // Asynchronous reset asserted between clock edges
  task automatic pulseReset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    tick  = 1'b0;
    ones8 = 0; cnt8 = 0; ones64 = 0; cnt64 = 0;
    stim_phase = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; tick = 1'b0; en = 1'b0; mic_data = 1'b0; ready = 1'b0;
    ready_mode = 0; ready_at_close = 1'b0; stim_phase = 1'b0;
    ones8 = 0; cnt8 = 0; ones64 = 0; cnt64 = 0; cval8 = 0; cval64 = 0;
    #2 rst_n = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();

    $display("[TB] constant and alternating streams");
    ready_mode = 1;
    setEnable(1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'(i % 2));

    $display("[TB] ready only in the window-close cycle");
    ready_mode = 0;
    for (int i = 0; i < 8; i++) applyStimulus(1'($urandom_range(0, 1)));
    ready_at_close = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(1'($urandom_range(0, 1)));
    ready_at_close = 1'b0;
    ready_mode = 1;
    repeat (4) cycle();

    $display("[TB] enable dropped mid-window");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1);
    setEnable(1'b0);
    mic_data = 1'b1;
    sendTick();
    repeat (5) cycle();
    setEnable(1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'(i < 2));

    $display("[TB] random data with random ready");
    ready_mode = 2;
    for (int i = 0; i < 40; i++) applyStimulus(1'($urandom_range(0, 1)));

    $display("[TB] reset mid-window with a pending sample");
    pulseReset();
    ready_mode = 0;
    for (int i = 0; i < 8; i++) applyStimulus(1'($urandom_range(0, 1)));
    for (int i = 0; i < 3; i++) applyStimulus(1'($urandom_range(0, 1)));
    pulseReset();

    $display("[TB] two DECIM=64 windows with no consumer");
    ready_mode = 0;
    for (int i = 0; i < 128; i++) applyStimulus(1'($urandom_range(0, 1)));
    ready_mode = 1;
    repeat (4) cycle();
    ready_mode = 2;
    for (int i = 0; i < 8; i++) applyStimulus(1'($urandom_range(0, 1)));
    repeat (4) cycle();

    $display("[TB] dropped samples: dut8 %0d dut64 %0d", drops8, drops64);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mic_pdm_rx.md
# mic_pdm_rx

PDM microphone front end that consumes the mic-rate `tick` from the microphone clock divider. It drives the microphone clock pin and captures the 1-bit PDM stream. It decimates that stream with a boxcar (ones-count) filter into signed PCM samples. Samples are handed to the downstream feature pipeline over a valid/ready interface.

## Interface
Parameters:
- `DECIM`, default 64: PDM bits per output sample. Must be a power of two, ≥ 4.
- `SAMPLE_W`, default `$clog2(DECIM)+2`: signed output width (8 for DECIM=64).

Ports:
- `clk`, in, 1: system clock, the single clock of the block.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `tick`, in, 1: one-cycle strobe from the divider. Each strobe is one half-period of `mic_clk`.
- `en`, in, 1: capture enable.
- `mic_data`, in, 1: asynchronous PDM data pin.
- `mic_clk`, out, 1: microphone clock pin.
- `sample`, out, SAMPLE_W: signed PCM sample, two's complement.
- `sample_valid`, out, 1: `sample` holds an unconsumed value.
- `sample_ready`, in, 1: consumer accepts `sample` this cycle.
- `overrun`, out, 1: sticky flag that a sample was dropped. Present only with `MIC_PDM_OVERRUN_EN`.

## Operation
- `mic_data` passes through a 2-flop synchronizer. The synchronized bit is `pdm_s`.
- `en`=0:
  - `mic_clk` is forced to 0.
  - `bit_cnt` and `ones` are cleared.
  - The output register is not touched; a pending sample stays valid until consumed.
- `en`=1, on each `tick`:
  - If `mic_clk`=1: capture `pdm_s` (left-channel data, valid during the high phase), then drive `mic_clk` to 0.
  - If `mic_clk`=0: drive `mic_clk` to 1. No capture happens.
- Capture step:
  - Add `pdm_s` to `ones`. `ones` has width `$clog2(DECIM)+1`.
  - Increment `bit_cnt`, which wraps modulo DECIM.
- Window close, on the capture where `bit_cnt`=DECIM-1:
  - Compute `total = ones + pdm_s`.
  - Form the result `2*total - DECIM`, sign-extended to SAMPLE_W. Range is −DECIM to +DECIM.
  - Clear `ones` to 0 and `bit_cnt` to 0 in the same cycle.
- Output register (single entry):
  - A transfer occurs when `sample_valid & sample_ready`. On a transfer, `sample_valid` falls the next cycle unless a new sample loads in that same cycle.
  - Window close with the register empty, or with a transfer in the same cycle: load the new result, `sample_valid`=1.
  - Window close with `sample_valid`=1 and no transfer: drop the new result, keep the old `sample`, set `overrun` (when compiled in).
- `overrun` clears only on reset.

## Timing
- Reset values: `mic_clk`=0, `sample`=0, `sample_valid`=0, `overrun`=0.
  - All internal counters and synchronizer flops reset to 0.
  - Reset acts asynchronously, including mid-window and mid-handshake.
- `mic_data` to `pdm_s`: 2 `clk` cycles. The `tick` spacing of ≥15 cycles guarantees settled data at capture.
- Result to output: `sample_valid` rises the cycle after the window-closing capture cycle.
- A `tick` with `en`=0 is ignored.
- `en` rising: the next `tick` drives `mic_clk` to 1, and a fresh window starts from `bit_cnt`=0.
- `en` falling mid-window: the partial window is discarded.
- `sample` is stable while `sample_valid`=1 and not transferred.

## Configuration
- `MIC_PDM_OVERRUN_EN` defined: the `overrun` port and its sticky register exist.
- Not defined:
  - The port is absent.
  - The drop-on-full behaviour is unchanged, with no indication.

## Structure
- Shared package `mic_pkg` holds:
  - `MIC_DECIM_DEFAULT` = 64.
  - A width function `mic_sample_w(decim)` returning `$clog2(decim)+2`.
  - The sample typedef for the default width.
- One sub-module, `mic_sync2`: 2-flop synchronizer with async active-low reset. It is reused elsewhere in the codebase for the mic pins.

## Test plan
Common setup: `tick` every 16 cycles unless stated, `en`=1.
- DECIM=8, `mic_data`=1 constant, `sample_ready`=1 → first `sample_valid` after 16 ticks, `sample`=+8 (5'b01000).
- DECIM=8, `mic_data`=0 constant → `sample`=−8 (5'b11000). DECIM=8, data alternating per captured bit → `sample`=0.
- DECIM=64, `sample_ready`=0 for two windows → first sample held unchanged, `overrun`=1 after second window close, second sample lost.
- DECIM=8, `sample_ready` asserted in exactly the window-close cycle → old sample transferred, new sample loaded, `sample_valid` stays 1, `overrun`=0.
- `en` dropped after 3 captures, raised again → `mic_clk` held 0 while `en`=0, next sample reflects only post-enable bits.
- `rst_n` pulsed low mid-window with `sample_valid`=1 → `sample_valid`, `sample`, `mic_clk`, `overrun` go to 0 without waiting for a `clk` edge.
